// File: rtl/rinstr_encoder.sv
// rinstr_encoder: packs RV32I R-type fields into words and streams them into imem at consecutive addresses; word visible one edge after accept.
// Backpressure: in_ready drops when the FIFO is full or restart is high. Optional legality filter under RINSTR_FIELD_CHECK_EN.

module rinstr_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   push,
  input  logic [W-1:0]           wdata,
  input  logic                   pop,
  output logic [W-1:0]           rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the read side is masked while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end
endmodule

module rinstr_encoder #(
  parameter int DEPTH     = 4,
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   restart,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [6:0]             funct7,
  input  logic [4:0]             rs2,
  input  logic [4:0]             rs1,
  input  logic [2:0]             funct3,
  input  logic [4:0]             rd,
  output logic                   imem_we,
  output logic [ADDR_W-1:0]      imem_addr,
  output logic [31:0]            imem_wdata,
  input  logic                   imem_ack,
  output logic [$clog2(DEPTH):0] level,
  output logic                   err
);
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
  localparam logic [6:0]        OPC_R = 7'b0110011;

  typedef struct packed {
    logic [6:0] funct7;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic [6:0] opcode;
  } rtype_t;

  rtype_t            enc_word;
  logic [31:0]       head_dat;
  logic              fifo_full, fifo_empty;
  logic              accept, legal, push, xfer;
  logic [ADDR_W-1:0] addr_q, addr_d;

  assign enc_word = '{funct7: funct7, rs2: rs2, rs1: rs1, funct3: funct3,
                      rd: rd, opcode: OPC_R};

`ifdef RINSTR_FIELD_CHECK_EN
  // Only add/sll/slt/sltu/xor/srl/or/and plus sub and sra are legal.
  assign legal = (funct7 == 7'b0000000) ||
                 ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
`else
  assign legal = 1'b1;
`endif

  assign in_ready = !fifo_full && !restart;
  assign accept   = in_valid && in_ready;
  assign push     = accept && legal;
  assign imem_we  = !fifo_empty;
  assign xfer     = imem_we && imem_ack;

  rinstr_fifo #(
    .DEPTH (DEPTH),
    .W     (32)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (restart),
    .push  (push),
    .wdata (enc_word),
    .pop   (xfer),
    .rdata (head_dat),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (level)
  );

  assign imem_wdata = fifo_empty ? 32'h0 : head_dat;
  assign imem_addr  = addr_q;

  // restart beats a same-cycle transfer: the discarded write never advances the address.
  always_comb begin
    addr_d = addr_q;
    if (restart)   addr_d = BASE;
    else if (xfer) addr_d = addr_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) addr_q <= BASE;
    else        addr_q <= addr_d;
  end

`ifdef RINSTR_FIELD_CHECK_EN
  logic err_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= accept && !legal;
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif
endmodule
